bus_sequencer: RTL and testbench
================================

// Module: bus_sequencer
// PURPOSE
//  Drives the control side of the shared DATA bus: generates per-register ENABLE/RW/COUNT strobes
//  so a bidirectional register drives the bus and another captures it. Accepts one transfer
//  request at a time via valid/ready, sequences it, pulses DONE. Sits between the control unit
//  and the register file. Guarantees a single bus driver per cycle.
// PARAMETERS
//  NUM_REGS   8  number of bus registers controlled (2..16)
//  SEL_WIDTH  4  width of register index fields; indices >= NUM_REGS are invalid
// PORTS
//  CLOCK      in   1         single clock, all state on posedge
//  RESET      in   1         synchronous, active-high
//  REQ_VALID  in   1         request present
//  REQ_READY  out  1         sequencer idle, request accepted on VALID&READY
//  REQ_OP     in   2         00 MOVE, 01 MOVE_INC, 10 INC, 11 reserved (error)
//  REQ_SRC    in   SEL_WIDTH source register index (driven onto bus / incremented)
//  REQ_DST    in   SEL_WIDTH destination register index (captures bus); ignored for INC
//  REG_EN     out  NUM_REGS  per-register ENABLE
//  REG_RW     out  NUM_REGS  per-register RW (1 write-to-bus/hold, 0 read-from-bus)
//  REG_COUNT  out  NUM_REGS  per-register COUNT strobe
//  DONE       out  1         1-cycle pulse, operation complete
//  ERROR      out  1         1-cycle pulse, request rejected
// BEHAVIOUR
//  - Reset: state IDLE; REG_EN=0, REG_RW=all 1, REG_COUNT=0, DONE=0, ERROR=0; REQ_READY=1
//    in the first cycle after RESET deasserts. Reset mid-operation aborts; no DONE issued.
//  - All REG_*, DONE, ERROR are registered. REQ_READY = (state==IDLE), combinational.
//  - REQ_* sampled only on VALID&READY (cycle T); ignored otherwise.
//  - States: IDLE, DRIVE, CAPTURE, FINISH, FAULT.
//  - Validation at T: src>=NUM_REGS, (MOVE/MOVE_INC and (dst>=NUM_REGS or dst==src)), or
//    OP=11 -> FAULT: T+1 ERROR=1, all REG_EN=0, no COUNT; T+2 IDLE.
//  - MOVE/MOVE_INC: T+1 DRIVE: EN[src]=1, RW[src]=1 (register outputs onto DATA at T+1 edge end).
//    T+2 CAPTURE: EN[src]=1 RW[src]=1, EN[dst]=1 RW[dst]=0; dst latches DATA at end of T+2.
//    T+3 FINISH: REG_EN=0, RW all 1, DONE=1; COUNT[src]=1 only for MOVE_INC. T+4 IDLE, READY=1.
//  - INC: T+1 FINISH: REG_EN=0, COUNT[src]=1, DONE=1. T+2 IDLE.
//  - REG_RW bits are 1 in every cycle except RW[dst] in CAPTURE (registers count only with RW=1).
//  - Invariants: at most one bit of REG_EN&REG_RW set; at most one bit of REG_COUNT set;
//    REG_COUNT never coincides with any REG_EN bit; DONE and ERROR never both high.
//  - Back-to-back: new request accepted in the IDLE cycle after FINISH/FAULT; no pipelining.
//  - Width rules: indices compared unsigned at SEL_WIDTH; one-hot vectors exactly NUM_REGS wide.
// STRUCTURE
//  - Package bat_bus_pkg: OP_MOVE/OP_MOVE_INC/OP_INC/OP_RSVD encodings, state enum
//    (IDLE, DRIVE, CAPTURE, FINISH, FAULT), RW_READ=0 / RW_WRITE=1 constants.
//  - Sub-module onehot_decode (parameters NUM_REGS, SEL_WIDTH; index+enable -> one-hot),
//    instanced for src and dst; FSM and output registers in this module.
//  - Latch src/dst one-hot and op into holding registers at acceptance.
// TESTING
//  - Reset: assert RESET 2 cycles during CAPTURE -> next cycle REG_EN=0, RW=all 1, no DONE, READY=1.
//  - MOVE src=2 dst=5 with bidi register models, R2=16'hBEEF -> R5=16'hBEEF at T+3, DONE at T+3,
//    REG_EN=8'h04 at T+1, 8'h24 with RW=8'hDF at T+2.
//  - MOVE_INC src=0 dst=1, R0=16'h00FF -> R1=16'h00FF, R0=16'h0100 after T+3, COUNT=8'h01 at T+3.
//  - INC src=7, R7=16'hFFFF -> R7=16'h0000 (wrap), DONE at T+1, no REG_EN activity.
//  - Errors: src=9 (NUM_REGS=8), MOVE src=dst=3, OP=11 -> ERROR pulse at T+1, registers unchanged.
//  - Back-to-back VALID held high with 3 requests -> accepted at T, T+4, T+8; single-driver
//    assertion and REG_COUNT/REG_EN exclusivity checked every cycle.

Source files
------------

// File: rtl/bat_bus_pkg.sv
// Shared encodings for the DATA-bus sequencer: opcodes, FSM states, RW levels.
package bat_bus_pkg;

  localparam logic [1:0] OP_MOVE     = 2'b00;
  localparam logic [1:0] OP_MOVE_INC = 2'b01;
  localparam logic [1:0] OP_INC      = 2'b10;
  localparam logic [1:0] OP_RSVD     = 2'b11;

  // RW level seen by a bus register: READ captures DATA, WRITE drives/holds.
  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRIVE   = 3'd1,
    CAPTURE = 3'd2,
    FINISH  = 3'd3,
    FAULT   = 3'd4
  } state_e;

endpackage

// File: rtl/onehot_decode.sv
// Index-to-one-hot decoder. Out-of-range indices give an all-zero vector
// and valid_o=0 so the caller can reject the request.
module onehot_decode #(
  parameter int NUM_REGS  = 8,
  parameter int SEL_WIDTH = 4
) (
  input  logic [SEL_WIDTH-1:0] idx_i,
  input  logic                 en_i,
  output logic [NUM_REGS-1:0]  onehot_o,
  output logic                 valid_o
);

  localparam int               LIMIT_W = SEL_WIDTH + 1;
  localparam logic [SEL_WIDTH:0] LIMIT = LIMIT_W'(NUM_REGS);

  // Unsigned range check, one bit wider so NUM_REGS == 2**SEL_WIDTH still fits.
  assign valid_o = ({1'b0, idx_i} < LIMIT);

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_bit
      assign onehot_o[gi] = en_i && (idx_i == SEL_WIDTH'(gi));
    end
  endgenerate

endmodule

// File: rtl/bus_sequencer.sv
// Control-side sequencer for the shared DATA bus. Takes one transfer request
// at a time, walks DRIVE -> CAPTURE -> FINISH (or FINISH / FAULT directly),
// and produces registered per-register ENABLE/RW/COUNT strobes so that at
// most one register ever drives the bus.
module bus_sequencer
  import bat_bus_pkg::*;
#(
  parameter int NUM_REGS  = 8,
  parameter int SEL_WIDTH = 4
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 REQ_VALID,
  output logic                 REQ_READY,
  input  logic [1:0]           REQ_OP,
  input  logic [SEL_WIDTH-1:0] REQ_SRC,
  input  logic [SEL_WIDTH-1:0] REQ_DST,
  output logic [NUM_REGS-1:0]  REG_EN,
  output logic [NUM_REGS-1:0]  REG_RW,
  output logic [NUM_REGS-1:0]  REG_COUNT,
  output logic                 DONE,
  output logic                 ERROR
);

  state_e              state_q, state_d;
  logic [NUM_REGS-1:0] src_oh_q, src_oh_d;
  logic [NUM_REGS-1:0] dst_oh_q, dst_oh_d;
  logic [1:0]          op_q, op_d;

  logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
  logic [NUM_REGS-1:0] reg_rw_q, reg_rw_d;
  logic [NUM_REGS-1:0] reg_count_q, reg_count_d;
  logic                done_q, done_d;
  logic                error_q, error_d;

  logic                accept;
  logic                is_move;
  logic                src_ok;
  logic                dst_ok;
  logic                req_bad;
  logic [NUM_REGS-1:0] src_dec;
  logic [NUM_REGS-1:0] dst_dec;

  assign REQ_READY = (state_q == IDLE);
  assign accept    = REQ_VALID && REQ_READY;
  assign is_move   = (REQ_OP == OP_MOVE) || (REQ_OP == OP_MOVE_INC);

  onehot_decode #(
    .NUM_REGS  (NUM_REGS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_src_dec (
    .idx_i    (REQ_SRC),
    .en_i     (accept),
    .onehot_o (src_dec),
    .valid_o  (src_ok)
  );

  // The destination is meaningless for INC, so its one-hot stays empty there.
  onehot_decode #(
    .NUM_REGS  (NUM_REGS),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_dst_dec (
    .idx_i    (REQ_DST),
    .en_i     (accept && is_move),
    .onehot_o (dst_dec),
    .valid_o  (dst_ok)
  );

  // A transfer onto itself would need two drivers' worth of RW, so it is rejected.
  assign req_bad = (REQ_OP == OP_RSVD) || !src_ok ||
                   (is_move && (!dst_ok || (REQ_SRC == REQ_DST)));

  // Next state and holding registers; the request is latched only on acceptance.
  always_comb begin
    state_d  = state_q;
    src_oh_d = src_oh_q;
    dst_oh_d = dst_oh_q;
    op_d     = op_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          src_oh_d = src_dec;
          dst_oh_d = dst_dec;
          op_d     = REQ_OP;
          if (req_bad) begin
            state_d = FAULT;
          end else if (REQ_OP == OP_INC) begin
            state_d = FINISH;
          end else begin
            state_d = DRIVE;
          end
        end
      end
      DRIVE:   state_d = CAPTURE;
      CAPTURE: state_d = FINISH;
      FINISH:  state_d = IDLE;
      FAULT:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output strobes are decoded from the upcoming state so they register in step with it.
  always_comb begin
    reg_en_d    = '0;
    reg_rw_d    = {NUM_REGS{RW_WRITE}};
    reg_count_d = '0;
    done_d      = 1'b0;
    error_d     = 1'b0;
    case (state_d)
      DRIVE: begin
        reg_en_d = src_oh_d;
      end
      CAPTURE: begin
        // Source keeps driving while the destination alone switches to capture.
        reg_en_d = src_oh_d | dst_oh_d;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (dst_oh_d[i]) begin
            reg_rw_d[i] = RW_READ;
          end
        end
      end
      FINISH: begin
        done_d = 1'b1;
        if ((op_d == OP_MOVE_INC) || (op_d == OP_INC)) begin
          reg_count_d = src_oh_d;
        end
      end
      FAULT: begin
        error_d = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // State, holding and output registers; reset aborts any transfer in flight.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= IDLE;
      src_oh_q    <= '0;
      dst_oh_q    <= '0;
      op_q        <= OP_MOVE;
      reg_en_q    <= '0;
      reg_rw_q    <= {NUM_REGS{RW_WRITE}};
      reg_count_q <= '0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      src_oh_q    <= src_oh_d;
      dst_oh_q    <= dst_oh_d;
      op_q        <= op_d;
      reg_en_q    <= reg_en_d;
      reg_rw_q    <= reg_rw_d;
      reg_count_q <= reg_count_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign REG_EN    = reg_en_q;
  assign REG_RW    = reg_rw_q;
  assign REG_COUNT = reg_count_q;
  assign DONE      = done_q;
  assign ERROR     = error_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Bench for bus_sequencer: bidirectional register models on a shared DATA bus,
// a completion scoreboard, per-cycle invariants and a table of transfers.
module tb_bus_sequencer;
  import bat_bus_pkg::*;

  localparam int NR = 8;
  localparam int SW = 4;

  logic          CLOCK = 1'b0;
  logic          RESET = 1'b1;
  logic          REQ_VALID = 1'b0;
  logic          REQ_READY;
  logic [1:0]    REQ_OP = 2'b00;
  logic [SW-1:0] REQ_SRC = '0;
  logic [SW-1:0] REQ_DST = '0;
  logic [NR-1:0] REG_EN;
  logic [NR-1:0] REG_RW;
  logic [NR-1:0] REG_COUNT;
  logic          DONE;
  logic          ERROR;

  bus_sequencer #(.NUM_REGS(NR), .SEL_WIDTH(SW)) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .REQ_VALID (REQ_VALID),
    .REQ_READY (REQ_READY),
    .REQ_OP    (REQ_OP),
    .REQ_SRC   (REQ_SRC),
    .REQ_DST   (REQ_DST),
    .REG_EN    (REG_EN),
    .REG_RW    (REG_RW),
    .REG_COUNT (REG_COUNT),
    .DONE      (DONE),
    .ERROR     (ERROR)
  );

  always #5 CLOCK = ~CLOCK;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register file model: EN&RW drives DATA, EN&!RW captures it, COUNT increments.
  logic [15:0] regs_m [NR];
  logic        pl_en  = 1'b0;
  logic [2:0]  pl_idx = '0;
  logic [15:0] pl_val = '0;

  always @(posedge CLOCK) begin : reg_model
    logic [15:0] bus;
    cyc = cyc + 1;
    bus = 16'h0000;
    for (int i = 0; i < NR; i++) begin
      if (REG_EN[i] && REG_RW[i]) bus = regs_m[i];
    end
    if (pl_en) begin
      regs_m[pl_idx] = pl_val;
    end else begin
      for (int i = 0; i < NR; i++) begin
        if (REG_EN[i] && !REG_RW[i]) regs_m[i] = bus;
        else if (REG_COUNT[i] && REG_RW[i]) regs_m[i] = regs_m[i] + 16'd1;
      end
    end
  end

  // Scoreboard: each accepted request predicts its completion kind and cycle.
  typedef struct {
    bit is_err;
    int due;
  } sb_t;
  sb_t sb[$];

  function automatic bit model_is_err(input logic [1:0] op, input logic [SW-1:0] s, input logic [SW-1:0] d);
    bit mv;
    mv = (op == OP_MOVE) || (op == OP_MOVE_INC);
    return (op == OP_RSVD) || (int'(s) >= NR) || (mv && ((int'(d) >= NR) || (s == d)));
  endfunction

  always @(negedge CLOCK) begin : monitor
    sb_t e;
    sb_t n;
    if (RESET) begin
      sb.delete();
    end else begin
      chk("inv_one_driver", 32'($countones(REG_EN & REG_RW) <= 1), 32'd1);
      chk("inv_count_onehot", 32'($countones(REG_COUNT) <= 1), 32'd1);
      chk("inv_count_vs_en", 32'(REG_COUNT & REG_EN), 32'd0);
      chk("inv_done_err", 32'(DONE && ERROR), 32'd0);
      if (DONE || ERROR) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected", {30'd0, DONE, ERROR}, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("sb_kind", 32'(ERROR), 32'(e.is_err));
          chk("sb_time", cyc, e.due);
        end
      end
      if (REQ_VALID && REQ_READY) begin
        n.is_err = model_is_err(REQ_OP, REQ_SRC, REQ_DST);
        n.due    = cyc + ((n.is_err || (REQ_OP == OP_INC)) ? 1 : 3);
        sb.push_back(n);
      end
    end
  end

  typedef struct {
    logic [1:0]    op;
    logic [SW-1:0] src;
    logic [SW-1:0] dst;
    bit            err;
    logic [NR-1:0] en1;
    logic [NR-1:0] en2;
    logic [NR-1:0] rw2;
    logic [NR-1:0] cnt_fin;
    int            c1_idx;
    logic [15:0]   c1_val;
    int            c2_idx;
    logic [15:0]   c2_val;
  } vec_t;

  vec_t vecs [10];

  task automatic wait_ready(input string tag);
    int w = 0;
    while (!REQ_READY && w < 10) begin
      @(negedge CLOCK);
      w++;
    end
    chk({tag, "_ready"}, 32'(REQ_READY), 32'd1);
  endtask

  task automatic run_vec(input vec_t v, input int id);
    int            lat;
    logic [NR-1:0] e_en, e_rw, e_cnt;
    logic          e_done, e_err;
    wait_ready($sformatf("v%0d", id));
    @(posedge CLOCK); #1;
    REQ_VALID = 1'b1; REQ_OP = v.op; REQ_SRC = v.src; REQ_DST = v.dst;
    @(posedge CLOCK); #1;
    REQ_VALID = 1'b0;
    REQ_OP  = 2'($urandom_range(3));
    REQ_SRC = SW'($urandom_range(15));
    REQ_DST = SW'($urandom_range(15));
    lat = (v.err || (v.op == OP_INC)) ? 1 : 3;
    for (int k = 1; k <= lat; k++) begin
      @(negedge CLOCK);
      e_en = '0; e_rw = '1; e_cnt = '0; e_done = 1'b0; e_err = 1'b0;
      if (v.err) e_err = 1'b1;
      else if (k == lat) begin e_done = 1'b1; e_cnt = v.cnt_fin; end
      else if (k == 1) e_en = v.en1;
      else begin e_en = v.en2; e_rw = v.rw2; end
      chk($sformatf("v%0d_t%0d_en", id, k), 32'(REG_EN), 32'(e_en));
      chk($sformatf("v%0d_t%0d_rw", id, k), 32'(REG_RW), 32'(e_rw));
      chk($sformatf("v%0d_t%0d_cnt", id, k), 32'(REG_COUNT), 32'(e_cnt));
      chk($sformatf("v%0d_t%0d_done", id, k), 32'(DONE), 32'(e_done));
      chk($sformatf("v%0d_t%0d_err", id, k), 32'(ERROR), 32'(e_err));
      chk($sformatf("v%0d_t%0d_busy", id, k), 32'(REQ_READY), 32'd0);
    end
    @(negedge CLOCK);
    chk($sformatf("v%0d_idle_ready", id), 32'(REQ_READY), 32'd1);
    chk($sformatf("v%0d_idle_en", id), 32'(REG_EN), 32'd0);
    chk($sformatf("v%0d_idle_done", id), 32'(DONE), 32'd0);
    chk($sformatf("v%0d_r%0d", id, v.c1_idx), 32'(regs_m[v.c1_idx]), 32'(v.c1_val));
    chk($sformatf("v%0d_r%0d", id, v.c2_idx), 32'(regs_m[v.c2_idx]), 32'(v.c2_val));
  endtask

  task automatic preload(input int idx, input logic [15:0] val);
    pl_en = 1'b1; pl_idx = 3'(idx); pl_val = val;
    @(posedge CLOCK); #1;
    pl_en = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int acc [3];
    int nacc;
    int guard;
    vec_t rec;

    //          op           src    dst    err   en1    en2    rw2    cnt    c1  val        c2  val
    vecs[0] = '{OP_MOVE,     4'd2,  4'd5,  1'b0, 8'h04, 8'h24, 8'hDF, 8'h00, 5, 16'hBEEF, 2, 16'hBEEF};
    vecs[1] = '{OP_MOVE_INC, 4'd0,  4'd1,  1'b0, 8'h01, 8'h03, 8'hFD, 8'h01, 1, 16'h00FF, 0, 16'h0100};
    vecs[2] = '{OP_INC,      4'd7,  4'd0,  1'b0, 8'h00, 8'h00, 8'hFF, 8'h80, 7, 16'h0000, 6, 16'h6666};
    vecs[3] = '{OP_MOVE,     4'd9,  4'd1,  1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 1, 16'h00FF, 7, 16'h0000};
    vecs[4] = '{OP_MOVE,     4'd3,  4'd3,  1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 3, 16'h3333, 0, 16'h0100};
    vecs[5] = '{OP_RSVD,     4'd1,  4'd2,  1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 2, 16'hBEEF, 1, 16'h00FF};
    vecs[6] = '{OP_INC,      4'd8,  4'd0,  1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 0, 16'h0100, 7, 16'h0000};
    vecs[7] = '{OP_MOVE_INC, 4'd5,  4'd6,  1'b0, 8'h20, 8'h60, 8'hBF, 8'h20, 6, 16'hBEEF, 5, 16'hBEF0};
    vecs[8] = '{OP_MOVE,     4'd4,  4'd15, 1'b1, 8'h00, 8'h00, 8'hFF, 8'h00, 4, 16'h4444, 6, 16'hBEEF};
    vecs[9] = '{OP_INC,      4'd4,  4'd12, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h10, 4, 16'h4445, 3, 16'h3333};

    // Load the register models while the sequencer is held in reset.
    RESET = 1'b1;
    @(posedge CLOCK); #1;
    preload(0, 16'h00FF);
    preload(1, 16'h0000);
    preload(2, 16'hBEEF);
    preload(3, 16'h3333);
    preload(4, 16'h4444);
    preload(5, 16'h0000);
    preload(6, 16'h6666);
    preload(7, 16'hFFFF);
    RESET = 1'b0;
    @(negedge CLOCK);
    chk("rst_ready", 32'(REQ_READY), 32'd1);
    chk("rst_en", 32'(REG_EN), 32'd0);
    chk("rst_rw", 32'(REG_RW), 32'hFF);
    chk("rst_count", 32'(REG_COUNT), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_error", 32'(ERROR), 32'd0);

    for (int i = 0; i < 10; i++) begin
      run_vec(vecs[i], i);
    end

    // Back-to-back: VALID stays high across three MOVE-class requests.
    wait_ready("b2b");
    nacc = 0; guard = 0;
    acc[0] = 0; acc[1] = 0; acc[2] = 0;
    @(posedge CLOCK); #1;
    REQ_VALID = 1'b1; REQ_OP = OP_MOVE; REQ_SRC = 4'd0; REQ_DST = 4'd1;
    while (nacc < 3 && guard < 40) begin
      @(negedge CLOCK);
      guard++;
      if (REQ_READY) begin
        acc[nacc] = cyc + 1;
        nacc++;
        @(posedge CLOCK); #1;
        if (nacc == 1) begin REQ_OP = OP_MOVE_INC; REQ_SRC = 4'd2; REQ_DST = 4'd3; end
        else if (nacc == 2) begin REQ_OP = OP_MOVE; REQ_SRC = 4'd3; REQ_DST = 4'd4; end
        else REQ_VALID = 1'b0;
      end
    end
    REQ_VALID = 1'b0;
    chk("b2b_accepts", 32'(nacc), 32'd3);
    chk("b2b_gap1", 32'(acc[1] - acc[0]), 32'd4);
    chk("b2b_gap2", 32'(acc[2] - acc[1]), 32'd4);

    // Reset held for two cycles starting in CAPTURE must abort without DONE.
    wait_ready("rst_mid");
    @(posedge CLOCK); #1;
    REQ_VALID = 1'b1; REQ_OP = OP_MOVE; REQ_SRC = 4'd2; REQ_DST = 4'd4;
    @(posedge CLOCK); #1;
    REQ_VALID = 1'b0;
    @(negedge CLOCK);
    chk("rst_mid_drive_en", 32'(REG_EN), 32'h04);
    @(negedge CLOCK);
    chk("rst_mid_capture_en", 32'(REG_EN), 32'h14);
    chk("rst_mid_capture_rw", 32'(REG_RW), 32'hEF);
    RESET = 1'b1;
    @(posedge CLOCK);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    @(negedge CLOCK);
    chk("rst_mid_en", 32'(REG_EN), 32'd0);
    chk("rst_mid_rw", 32'(REG_RW), 32'hFF);
    chk("rst_mid_count", 32'(REG_COUNT), 32'd0);
    chk("rst_mid_done", 32'(DONE), 32'd0);
    chk("rst_mid_ready", 32'(REQ_READY), 32'd1);
    repeat (3) @(negedge CLOCK);

    // Recovery after the aborted transfer (R1 was 16'h0100 after the back-to-back moves).
    rec = '{OP_INC, 4'd1, 4'd0, 1'b0, 8'h00, 8'h00, 8'hFF, 8'h02, 1, 16'h0101, 3, 16'hBEEF};
    run_vec(rec, 10);

    repeat (4) @(negedge CLOCK);
    chk("sb_drain", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
